// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue -- register-file write-back queue
//
// Collects register writes from a load (mem) channel and an ALU channel into
// a small circular FIFO. The FIFO drains one entry per clock into the
// register file. Lookup ports let the operand-read stage forward data from
// writes that are still queued.
//
// Ports
//   clk                         single clock, rising edge
//   rst                         asynchronous reset, active low
//   mem_valid/mem_reg/mem_data  load-result write request
//   mem_ready                   load request is accepted this cycle
//   alu_valid/alu_reg/alu_data  ALU-result write request
//   alu_ready                   ALU request is accepted this cycle
//   write_en/write_reg/write_data  register-file write port (head entry)
//   lk_reg_1/2                  forwarding lookup addresses
//   lk_hit_1/2, lk_data_1/2     youngest queued write to the looked-up register
// ---------------------------------------------------------------------------
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        mem_ready,

    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_ready,

    output logic        write_en,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,

    input  logic [4:0]  lk_reg_1,
    input  logic [4:0]  lk_reg_2,
    output logic        lk_hit_1,
    output logic        lk_hit_2,
    output logic [31:0] lk_data_1,
    output logic [31:0] lk_data_2
);

    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - 1);

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } lookup_t;

    entry_t            fifo [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              mem_fire;
    logic              alu_fire;
    logic              mem_push;
    logic              alu_push;
    logic              pop;
    logic [PTR_W-1:0]  tail_alu;
    logic [CNT_W-1:0]  count_nxt;

    lookup_t           lk_1;
    lookup_t           lk_2;

    // Readies use the registered count only; the pop happening this cycle is
    // deliberately not credited so ready never has a path from the drain.
    // The ALU channel may take the last free slot only when mem does not
    // want it, since mem wins the slot when both arrive together.
    assign mem_ready = (count < CNT_FULL);
    assign alu_ready = (count < CNT_AF) || ((count == CNT_AF) && !mem_valid);

    assign mem_fire = mem_valid && mem_ready;
    assign alu_fire = alu_valid && alu_ready;

    // Writes to r0 complete the handshake but never occupy a slot.
    assign mem_push = mem_fire && (mem_reg != 5'd0);
    assign alu_push = alu_fire && (alu_reg != 5'd0);

    assign pop = (count != '0);

    // When both channels push, mem takes the tail slot (older) and alu the
    // next one.
    assign tail_alu  = tail + PTR_W'(mem_push);
    assign count_nxt = count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(mem_push) + PTR_W'(alu_push);
            count <= count_nxt;
        end
    end

    // Entry storage carries no reset; validity is defined by head/count.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            fifo[tail] <= '{rd: mem_reg, data: mem_data};
        end
        if (alu_push) begin
            fifo[tail_alu] <= '{rd: alu_reg, data: alu_data};
        end
    end

    assign write_en   = pop;
    assign write_reg  = pop ? fifo[head].rd   : 5'd0;
    assign write_data = pop ? fifo[head].data : '0;

    // Walks the occupied slots from oldest to youngest so that a later match
    // overrides an earlier one, leaving the youngest write's data.
    function automatic lookup_t lookup(input logic [4:0] rd);
        lookup_t          res;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (rd != 5'd0) && (fifo[idx].rd == rd)) begin
                res.hit  = 1'b1;
                res.data = fifo[idx].data;
            end
        end
        return res;
    endfunction

    always_comb begin
        lk_1 = lookup(lk_reg_1);
        lk_2 = lookup(lk_reg_2);
    end

    assign lk_hit_1  = lk_1.hit;
    assign lk_data_1 = lk_1.data;
    assign lk_hit_2  = lk_2.hit;
    assign lk_data_2 = lk_2.data;

endmodule

// File: tb/tb_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_queue -- directed, table-driven bench for wb_queue.
// A DEPTH=4 instance runs the vector table and the multi-cycle sequences;
// a DEPTH=2 instance covers the completely-full condition, which a queue
// that drains every cycle can only reach when both channels fill it at once.
// ---------------------------------------------------------------------------
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        mem_valid, alu_valid;
    logic [4:0]  mem_reg, alu_reg, lk_reg_1, lk_reg_2;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, write_en, lk_hit_1, lk_hit_2;
    logic [4:0]  write_reg;
    logic [31:0] write_data, lk_data_1, lk_data_2;

    logic        d2_mem_valid, d2_alu_valid;
    logic [4:0]  d2_mem_reg, d2_alu_reg;
    logic [31:0] d2_mem_data, d2_alu_data;
    logic        d2_mem_ready, d2_alu_ready, d2_write_en, d2_lk_hit_1, d2_lk_hit_2;
    logic [4:0]  d2_write_reg;
    logic [31:0] d2_write_data, d2_lk_data_1, d2_lk_data_2;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
        .lk_reg_1(lk_reg_1), .lk_reg_2(lk_reg_2),
        .lk_hit_1(lk_hit_1), .lk_hit_2(lk_hit_2),
        .lk_data_1(lk_data_1), .lk_data_2(lk_data_2)
    );

    wb_queue #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .mem_valid(d2_mem_valid), .mem_reg(d2_mem_reg), .mem_data(d2_mem_data), .mem_ready(d2_mem_ready),
        .alu_valid(d2_alu_valid), .alu_reg(d2_alu_reg), .alu_data(d2_alu_data), .alu_ready(d2_alu_ready),
        .write_en(d2_write_en), .write_reg(d2_write_reg), .write_data(d2_write_data),
        .lk_reg_1(5'd0), .lk_reg_2(5'd0),
        .lk_hit_1(d2_lk_hit_1), .lk_hit_2(d2_lk_hit_2),
        .lk_data_1(d2_lk_data_1), .lk_data_2(d2_lk_data_2)
    );

    typedef struct {
        logic        mv;  logic [4:0] mr; logic [31:0] md;
        logic        av;  logic [4:0] ar; logic [31:0] ad;
        logic [4:0]  l1;  logic [4:0] l2;
        logic        e_mrdy; logic e_ardy; logic e_we;
        logic [4:0]  e_wr; logic [31:0] e_wd;
        logic        e_h1; logic [31:0] e_d1;
        logic        e_h2; logic [31:0] e_d2;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic mv, input logic [4:0] mr, input logic [31:0] md,
        input logic av, input logic [4:0] ar, input logic [31:0] ad,
        input logic [4:0] l1, input logic [4:0] l2,
        input logic mrdy, input logic ardy, input logic we,
        input logic [4:0] wr, input logic [31:0] wd,
        input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2);
        vec_t v;
        v.mv = mv; v.mr = mr; v.md = md; v.av = av; v.ar = ar; v.ad = ad;
        v.l1 = l1; v.l2 = l2;
        v.e_mrdy = mrdy; v.e_ardy = ardy; v.e_we = we; v.e_wr = wr; v.e_wd = wd;
        v.e_h1 = h1; v.e_d1 = d1; v.e_h2 = h2; v.e_d2 = d2;
        return v;
    endfunction

    task automatic drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic [4:0] l1, input logic [4:0] l2);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        lk_reg_1 = l1; lk_reg_2 = l2;
    endtask

    task automatic d2_drive(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                            input logic av, input logic [4:0] ar, input logic [31:0] ad);
        d2_mem_valid = mv; d2_mem_reg = mr; d2_mem_data = md;
        d2_alu_valid = av; d2_alu_reg = ar; d2_alu_data = ad;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        d2_drive(0, 0, 0, 0, 0, 0);

        //        mv mr  md       av ar  ad            l1  l2  mrd ard we wr  wd      h1 d1      h2 d2
        vt[0]  = mk(0, 0, 0,       0, 0, 0,            0,  0,  1,  1,  0, 0,  0,      0, 0,      0, 0);
        vt[1]  = mk(0, 0, 0,       1, 5, 32'hAA,       5,  0,  1,  1,  0, 0,  0,      0, 0,      0, 0);
        vt[2]  = mk(0, 0, 0,       0, 0, 0,            5,  0,  1,  1,  1, 5,  32'hAA, 1, 32'hAA, 0, 0);
        vt[3]  = mk(0, 0, 0,       0, 0, 0,            5,  0,  1,  1,  0, 0,  0,      0, 0,      0, 0);
        vt[4]  = mk(1, 3, 32'h11,  1, 3, 32'h22,       3,  0,  1,  1,  0, 0,  0,      0, 0,      0, 0);
        vt[5]  = mk(0, 0, 0,       0, 0, 0,            3,  0,  1,  1,  1, 3,  32'h11, 1, 32'h22, 0, 0);
        vt[6]  = mk(0, 0, 0,       0, 0, 0,            3,  0,  1,  1,  1, 3,  32'h22, 1, 32'h22, 0, 0);
        vt[7]  = mk(0, 0, 0,       0, 0, 0,            3,  0,  1,  1,  0, 0,  0,      0, 0,      0, 0);
        vt[8]  = mk(0, 0, 0,       1, 0, 32'hFFFFFFFF, 0,  0,  1,  1,  0, 0,  0,      0, 0,      0, 0);
        vt[9]  = mk(0, 0, 0,       0, 0, 0,            0,  0,  1,  1,  0, 0,  0,      0, 0,      0, 0);
        vt[10] = mk(1, 1, 32'h101, 1, 2, 32'h202,      0,  0,  1,  1,  0, 0,  0,      0, 0,      0, 0);
        vt[11] = mk(1, 3, 32'h303, 1, 4, 32'h404,      1,  2,  1,  1,  1, 1,  32'h101,1, 32'h101,1, 32'h202);
        vt[12] = mk(1, 5, 32'h505, 1, 6, 32'h606,      4,  6,  1,  0,  1, 2,  32'h202,1, 32'h404,0, 0);
        vt[13] = mk(1, 7, 32'h707, 1, 6, 32'h606,      5,  3,  1,  0,  1, 3,  32'h303,1, 32'h505,1, 32'h303);
        vt[14] = mk(0, 0, 0,       1, 6, 32'h606,      6,  5,  1,  1,  1, 4,  32'h404,0, 0,      1, 32'h505);
        vt[15] = mk(0, 0, 0,       0, 0, 0,            6,  7,  1,  1,  1, 5,  32'h505,1, 32'h606,1, 32'h707);
        vt[16] = mk(0, 0, 0,       0, 0, 0,            6,  0,  1,  1,  1, 7,  32'h707,1, 32'h606,0, 0);
        vt[17] = mk(0, 0, 0,       0, 0, 0,            7,  0,  1,  1,  1, 6,  32'h606,0, 0,      0, 0);
        vt[18] = mk(0, 0, 0,       0, 0, 0,            0,  0,  1,  1,  0, 0,  0,      0, 0,      0, 0);

        // Reset state while reset is held
        next_cycle();
        next_cycle();
        chk("rst.write_en",  {31'd0, write_en},  32'd0);
        chk("rst.write_reg", {27'd0, write_reg}, 32'd0);
        chk("rst.write_data", write_data,        32'd0);
        chk("rst.lk_hit_1",  {31'd0, lk_hit_1},  32'd0);
        chk("rst.lk_data_1", lk_data_1,          32'd0);
        chk("rst.mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("rst.alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst.d2_mem_ready", {31'd0, d2_mem_ready}, 32'd1);
        chk("rst.d2_alu_ready", {31'd0, d2_alu_ready}, 32'd1);
        rst = 1'b1;
        next_cycle();

        // Vector table: one cycle per record, outputs checked before the edge
        for (int i = 0; i < 19; i++) begin
            drive(vt[i].mv, vt[i].mr, vt[i].md, vt[i].av, vt[i].ar, vt[i].ad, vt[i].l1, vt[i].l2);
            #1;
            chk($sformatf("v%0d.mem_ready", i),  {31'd0, mem_ready},  {31'd0, vt[i].e_mrdy});
            chk($sformatf("v%0d.alu_ready", i),  {31'd0, alu_ready},  {31'd0, vt[i].e_ardy});
            chk($sformatf("v%0d.write_en", i),   {31'd0, write_en},   {31'd0, vt[i].e_we});
            chk($sformatf("v%0d.write_reg", i),  {27'd0, write_reg},  {27'd0, vt[i].e_wr});
            chk($sformatf("v%0d.write_data", i), write_data,          vt[i].e_wd);
            chk($sformatf("v%0d.lk_hit_1", i),   {31'd0, lk_hit_1},   {31'd0, vt[i].e_h1});
            chk($sformatf("v%0d.lk_data_1", i),  lk_data_1,           vt[i].e_d1);
            chk($sformatf("v%0d.lk_hit_2", i),   {31'd0, lk_hit_2},   {31'd0, vt[i].e_h2});
            chk($sformatf("v%0d.lk_data_2", i),  lk_data_2,           vt[i].e_d2);
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Completely full queue on the DEPTH=2 instance
        d2_drive(1, 1, 32'h11, 1, 2, 32'h22);
        #1;
        chk("full.empty_ardy", {31'd0, d2_alu_ready}, 32'd1);
        next_cycle();
        d2_drive(1, 3, 32'h33, 1, 4, 32'h44);
        #1;
        chk("full.mem_ready", {31'd0, d2_mem_ready}, 32'd0);
        chk("full.alu_ready", {31'd0, d2_alu_ready}, 32'd0);
        chk("full.write_reg", {27'd0, d2_write_reg}, 32'd1);
        chk("full.write_data", d2_write_data, 32'h11);
        next_cycle();
        #1;
        chk("af.mem_ready", {31'd0, d2_mem_ready}, 32'd1);
        chk("af.alu_ready", {31'd0, d2_alu_ready}, 32'd0);
        chk("af.write_reg", {27'd0, d2_write_reg}, 32'd2);
        next_cycle();
        d2_drive(0, 0, 0, 1, 4, 32'h44);
        #1;
        chk("af2.alu_ready", {31'd0, d2_alu_ready}, 32'd1);
        chk("af2.write_reg", {27'd0, d2_write_reg}, 32'd3);
        chk("af2.write_data", d2_write_data, 32'h33);
        next_cycle();
        d2_drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("d2.last.write_reg", {27'd0, d2_write_reg}, 32'd4);
        chk("d2.last.write_data", d2_write_data, 32'h44);
        next_cycle();
        chk("d2.drained.write_en", {31'd0, d2_write_en}, 32'd0);

        // Reset in the middle of operation with three queued entries
        drive(1, 8, 32'h808, 1, 9, 32'h909, 0, 0);
        next_cycle();
        drive(1, 10, 32'hA0A, 1, 11, 32'hB0B, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 9, 11);
        #1;
        chk("pre_rst.write_reg", {27'd0, write_reg}, 32'd9);
        chk("pre_rst.lk_hit_2", {31'd0, lk_hit_2}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst.write_en", {31'd0, write_en}, 32'd0);
        chk("mid_rst.write_data", write_data, 32'd0);
        chk("mid_rst.lk_hit_1", {31'd0, lk_hit_1}, 32'd0);
        chk("mid_rst.lk_hit_2", {31'd0, lk_hit_2}, 32'd0);
        chk("mid_rst.lk_data_2", lk_data_2, 32'd0);
        chk("mid_rst.alu_ready", {31'd0, alu_ready}, 32'd1);
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("post_rst%0d.write_en", i), {31'd0, write_en}, 32'd0);
            chk($sformatf("post_rst%0d.lk_hit_1", i), {31'd0, lk_hit_1}, 32'd0);
            next_cycle();
        end

        // Wrap-around: ten single writes with an idle cycle between them
        for (int i = 1; i <= 10; i++) begin
            logic [4:0]  r;
            logic [31:0] d;
            r = 5'(i);
            d = 32'(i) * 32'h100;
            if (i % 2 == 1) drive(1, r, d, 0, 0, 0, r, 0);
            else            drive(0, 0, 0, 1, r, d, r, 0);
            #1;
            chk($sformatf("wrap%0d.idle_we", i), {31'd0, write_en}, 32'd0);
            chk($sformatf("wrap%0d.ready", i),
                {31'd0, (i % 2 == 1) ? mem_ready : alu_ready}, 32'd1);
            next_cycle();
            drive(0, 0, 0, 0, 0, 0, r, 0);
            #1;
            chk($sformatf("wrap%0d.write_en", i), {31'd0, write_en}, 32'd1);
            chk($sformatf("wrap%0d.write_reg", i), {27'd0, write_reg}, {27'd0, r});
            chk($sformatf("wrap%0d.write_data", i), write_data, d);
            chk($sformatf("wrap%0d.lk_data_1", i), lk_data_1, d);
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
